axis_frame_fifo: RTL and testbench
==================================

Name: axis_frame_fifo

Overview:
- Store-and-forward AXIS byte-frame buffer. Sits between an AXIS master-side producer (hit/readout formatter) and the AXIS consumer that drains toward the host interface.
- A frame is forwarded downstream only after its tlast byte is stored.
- Frames that cannot fit are dropped whole, never truncated. Drops are counted.

Parameters:
- DEPTH, 64, number of byte entries; power of 2, minimum 4.
- AW, $clog2(DEPTH), pointer width (derived, not overridable).
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resn  in  1  asynchronous, active-low reset.
- s_tdata  in  8  upstream byte.
- s_tdest  in  4  upstream destination.
- s_tid  in  2  upstream stream id.
- s_tuser  in  4  upstream user sideband.
- s_tvalid  in  1  upstream valid.
- s_tlast  in  1  upstream end of frame.
- s_tready  out  1  upstream ready.
- m_tdata  out  8  downstream byte.
- m_tdest  out  4  downstream destination.
- m_tid  out  2  downstream stream id.
- m_tuser  out  4  downstream user sideband.
- m_tvalid  out  1  downstream valid.
- m_tlast  out  1  downstream end of frame.
- m_tready  in  1  downstream ready.
- frame_count  out  AW+1  complete frames held.
- fill_level  out  AW+1  committed bytes held.
- drop_count  out  DROP_CNT_W  dropped frames; saturates at all-ones.
- overflow_pulse  out  1  one-cycle strobe per dropped frame.

Behaviour:
- Reset (resn low, asynchronous):
  - All pointers, counters and the state machine are cleared.
  - s_tready=0, m_tvalid=0, frame_count=0, fill_level=0, drop_count=0, overflow_pulse=0.
  - Any partial or stored frame is lost.
  - s_tready rises on the first clk edge after resn deasserts.
- Storage and handshakes:
  - Entry is {tlast,tuser,tid,tdest,tdata}, 19 bits.
  - Input handshake is s_tvalid&s_tready. Output handshake is m_tvalid&m_tready.
  - s_tready is 1 whenever out of reset. The block never backpressures; overflow is resolved by dropping.
- Pointers (AW+1 bits each, wrap naturally, MSB distinguishes full from empty):
  - wr_ptr: speculative write pointer.
  - wr_commit: start of the current frame, i.e. the last committed position.
  - rd_ptr: read pointer.
  - Full when wr_ptr-rd_ptr == DEPTH.
- Input state machine:
  - ACCEPT: each accepted byte is written at wr_ptr and wr_ptr increments.
    - On an accepted byte with tlast: wr_commit takes the post-increment wr_ptr and frame_count increments.
    - On an accepted byte while full: the byte is discarded, wr_ptr is restored to wr_commit, drop_count increments (saturating), overflow_pulse fires, and the state goes to DROP. If that byte also has tlast, the state stays in ACCEPT instead.
  - DROP: bytes are accepted and discarded. The accepted tlast byte returns the state to ACCEPT.
  - Any frame longer than DEPTH is therefore dropped.
- Output side:
  - First-word fall-through with an asynchronous memory read.
  - m_tvalid = (frame_count != 0).
  - m_* fields come from memory at rd_ptr.
  - rd_ptr increments on each output handshake.
  - frame_count decrements on an output handshake with m_tlast.
- Latency: a tlast accepted at edge k gives m_tvalid high in the cycle after edge k, if the FIFO was empty.
- Simultaneous events:
  - A frame commit on the same edge as an m_tlast handshake leaves frame_count unchanged.
  - fill_level = wr_commit-rd_ptr and is updated on the same edge.
  - A read that frees space in the same cycle a write finds the FIFO full is not credited. Full is evaluated on pre-edge pointers, so the frame is dropped.
- m_* outputs are stable while m_tvalid&!m_tready.
- Reset mid-frame behaves as the full reset above.
- Input tkeep is not a port and is not used.

Decomposition:
- Package axis_fifo_pkg:
  - AXIS_DATA_W=8, AXIS_DEST_W=4, AXIS_ID_W=2, AXIS_USER_W=4.
  - Packed struct axis_entry_t {tlast,tuser,tid,tdest,tdata}.
  - Enum in_state_t {ACCEPT,DROP}.
- One sub-module, axis_fifo_mem:
  - Simple dual-port RAM, DEPTH x $bits(axis_entry_t).
  - Synchronous write, asynchronous read.
- Pointer, counter and state logic live in axis_frame_fifo.

Test Plan:
- Single 3-byte frame 0x11,0x22,0x33 (tdest=5, tid=2, tuser=0xA, tlast on 0x33) with m_tready=1 -> m_tvalid rises the cycle after 0x33 is accepted; output bytes are 11,22,33 with sideband preserved and m_tlast on 33; frame_count goes 0→1→0.
- m_tvalid is never asserted while a partial frame is held: send 0x01,0x02 without tlast and wait 10 cycles -> m_tvalid=0, fill_level=0.
- DEPTH=64, m_tready=0: write 8 frames of 8 bytes -> frame_count=8, fill_level=64. Then write a 4-byte frame -> drop_count=1, one overflow_pulse, fill_level stays 64. Then drain all -> the original 64 bytes come out in order.
- Oversize frame of 70 bytes into an empty FIFO -> dropped; drop_count=1, frame_count=0. The next 2-byte frame is forwarded intact.
- Random m_tready at 50% with 200 back-to-back frames of random length 1–16 -> scoreboard matches byte-exact with no drops; simultaneous commit-and-read edges keep frame_count consistent.
- Assert resn low mid-frame with 2 frames stored -> all outputs are 0 asynchronously; after release the FIFO is empty and a new frame passes normally.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared types for the AXIS store-and-forward frame FIFO: field widths,
// the stored entry layout and the input-side state encoding.
package axis_fifo_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_ID_W   = 2;
  localparam int AXIS_USER_W = 4;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_USER_W-1:0] tuser;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_entry_t;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } in_state_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port entry RAM: synchronous write, asynchronous read so the
// FIFO head is visible in the same cycle (first-word fall-through).
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  axis_entry_t   wdata,
  input  logic [AW-1:0] raddr,
  output axis_entry_t   rdata
);

  axis_entry_t mem_r [DEPTH];

  // Entry write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXIS byte-frame FIFO. Frames become visible only once
// their tlast byte is stored; frames that do not fit are dropped whole.
module axis_frame_fifo
  import axis_fifo_pkg::*;
#(
  parameter  int DEPTH      = 64,
  parameter  int DROP_CNT_W = 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resn,
  input  logic [AXIS_DATA_W-1:0] s_tdata,
  input  logic [AXIS_DEST_W-1:0] s_tdest,
  input  logic [AXIS_ID_W-1:0]   s_tid,
  input  logic [AXIS_USER_W-1:0] s_tuser,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [AXIS_DATA_W-1:0] m_tdata,
  output logic [AXIS_DEST_W-1:0] m_tdest,
  output logic [AXIS_ID_W-1:0]   m_tid,
  output logic [AXIS_USER_W-1:0] m_tuser,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [AW:0]            frame_count,
  output logic [AW:0]            fill_level,
  output logic [DROP_CNT_W-1:0]  drop_count,
  output logic                   overflow_pulse
);

  localparam logic [AW:0]           PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]           FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [AW:0]           wr_ptr_r, wr_commit_r, rd_ptr_r;
  logic [AW:0]           frame_count_r, fill_level_r;
  logic [DROP_CNT_W-1:0] drop_count_r;
  logic                  s_tready_r, m_tvalid_r, overflow_r;
  in_state_t             state_r;

  logic [AW:0] wr_ptr_n_s, wr_commit_n_s, rd_ptr_n_s, frame_count_n_s;
  in_state_t   state_n_s;
  logic        in_hs_s, out_hs_s, full_s, mem_we_s, commit_s, drop_s;
  axis_entry_t wr_entry_s, rd_entry_s;

  assign in_hs_s  = s_tvalid & s_tready_r;
  assign out_hs_s = m_tvalid_r & m_tready;
  // Full is judged on pre-edge pointers, so a same-cycle read does not rescue a write.
  assign full_s   = ((wr_ptr_r - rd_ptr_r) == FULL_LVL);

  assign wr_entry_s = '{tlast: s_tlast, tuser: s_tuser, tid: s_tid,
                        tdest: s_tdest, tdata: s_tdata};

  axis_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // Input-side decisions: store, commit or drop the incoming byte.
  always_comb begin
    wr_ptr_n_s    = wr_ptr_r;
    wr_commit_n_s = wr_commit_r;
    state_n_s     = state_r;
    mem_we_s      = 1'b0;
    commit_s      = 1'b0;
    drop_s        = 1'b0;
    case (state_r)
      ACCEPT: begin
        if (in_hs_s && full_s) begin
          drop_s      = 1'b1;
          wr_ptr_n_s  = wr_commit_r;
          state_n_s   = s_tlast ? ACCEPT : DROP;
        end else if (in_hs_s) begin
          mem_we_s    = 1'b1;
          wr_ptr_n_s  = wr_ptr_r + PTR_ONE;
          if (s_tlast) begin
            commit_s      = 1'b1;
            wr_commit_n_s = wr_ptr_r + PTR_ONE;
          end else begin
            commit_s      = 1'b0;
          end
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      DROP: begin
        if (in_hs_s && s_tlast) begin
          state_n_s = ACCEPT;
        end else begin
          state_n_s = DROP;
        end
      end
      default: begin
        state_n_s = ACCEPT;
      end
    endcase
  end

  // Read pointer and frame count follow both handshakes on the same edge.
  always_comb begin
    rd_ptr_n_s      = out_hs_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    frame_count_n_s = frame_count_r;
    case ({commit_s, out_hs_s & rd_entry_s.tlast})
      2'b10:   frame_count_n_s = frame_count_r + PTR_ONE;
      2'b01:   frame_count_n_s = frame_count_r - PTR_ONE;
      default: frame_count_n_s = frame_count_r;
    endcase
  end

  // Pointer, counter, state and status registers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wr_ptr_r      <= '0;
      wr_commit_r   <= '0;
      rd_ptr_r      <= '0;
      frame_count_r <= '0;
      fill_level_r  <= '0;
      drop_count_r  <= '0;
      s_tready_r    <= 1'b0;
      m_tvalid_r    <= 1'b0;
      overflow_r    <= 1'b0;
      state_r       <= ACCEPT;
    end else begin
      wr_ptr_r      <= wr_ptr_n_s;
      wr_commit_r   <= wr_commit_n_s;
      rd_ptr_r      <= rd_ptr_n_s;
      frame_count_r <= frame_count_n_s;
      fill_level_r  <= wr_commit_n_s - rd_ptr_n_s;
      s_tready_r    <= 1'b1;
      m_tvalid_r    <= (frame_count_n_s != '0);
      overflow_r    <= drop_s;
      state_r       <= state_n_s;
      if (drop_s && (drop_count_r != DROP_MAX)) begin
        drop_count_r <= drop_count_r + DROP_ONE;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign s_tready       = s_tready_r;
  assign m_tvalid       = m_tvalid_r;
  assign m_tdata        = m_tvalid_r ? rd_entry_s.tdata : '0;
  assign m_tdest        = m_tvalid_r ? rd_entry_s.tdest : '0;
  assign m_tid          = m_tvalid_r ? rd_entry_s.tid   : '0;
  assign m_tuser        = m_tvalid_r ? rd_entry_s.tuser : '0;
  assign m_tlast        = m_tvalid_r ? rd_entry_s.tlast : 1'b0;
  assign frame_count    = frame_count_r;
  assign fill_level     = fill_level_r;
  assign drop_count     = drop_count_r;
  assign overflow_pulse = overflow_r;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based frame model.
module tb_axis_frame_fifo;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       resn;
  logic [7:0] s_tdata;
  logic [3:0] s_tdest;
  logic [1:0] s_tid;
  logic [3:0] s_tuser;
  logic       s_tvalid, s_tlast, s_tready;
  logic [7:0] m_tdata;
  logic [3:0] m_tdest;
  logic [1:0] m_tid;
  logic [3:0] m_tuser;
  logic       m_tvalid, m_tlast, m_tready;
  logic [6:0] frame_count, fill_level;
  logic [7:0] drop_count;
  logic       overflow_pulse;

  axis_frame_fifo dut (
    .clk(clk), .resn(resn),
    .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tid(s_tid), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tid(m_tid), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_count(frame_count), .fill_level(fill_level),
    .drop_count(drop_count), .overflow_pulse(overflow_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: committed bytes, the frame being received, drop status.
  typedef logic [18:0] ent_t;
  ent_t q_c[$];
  ent_t q_p[$];
  int   nfr, ndrop;
  bit   dropping, pulse_m, rdy_m, rand_rdy;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q_c.delete(); q_p.delete();
    nfr = 0; ndrop = 0; dropping = 1'b0; pulse_m = 1'b0; rdy_m = 1'b0;
  endfunction

  function automatic void model_edge();
    bit   full   = (q_c.size() + q_p.size()) == DEPTH;
    bit   in_hs  = s_tvalid && rdy_m;
    bit   out_hs = (nfr != 0) && m_tready;
    ent_t e;
    pulse_m = 1'b0;
    if (out_hs) begin
      e = q_c.pop_front();
      if (e[18]) nfr--;
    end
    if (in_hs) begin
      if (dropping) begin
        if (s_tlast) dropping = 1'b0;
      end else if (full) begin
        q_p.delete();
        if (ndrop < 255) ndrop++;
        pulse_m  = 1'b1;
        dropping = !s_tlast;
      end else begin
        q_p.push_back({s_tlast, s_tuser, s_tid, s_tdest, s_tdata});
        if (s_tlast) begin
          foreach (q_p[i]) q_c.push_back(q_p[i]);
          q_p.delete();
          nfr++;
        end
      end
    end
    rdy_m = 1'b1;
  endfunction

  task automatic compare_all();
    ent_t exp_e = (nfr != 0) ? q_c[0] : 19'h0;
    check_eq("s_tready", s_tready, rdy_m);
    check_eq("m_tvalid", m_tvalid, (nfr != 0));
    check_eq("m_entry", {m_tlast, m_tuser, m_tid, m_tdest, m_tdata}, exp_e);
    check_eq("frame_count", frame_count, nfr);
    check_eq("fill_level", fill_level, q_c.size());
    check_eq("drop_count", drop_count, ndrop);
    check_eq("overflow_pulse", overflow_pulse, pulse_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      s_tvalid = 1'b0;
      step();
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    check_eq({tag, "_s_tready"}, s_tready, 1'b0);
    check_eq({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    check_eq({tag, "_m_bus"}, {m_tlast, m_tuser, m_tid, m_tdest, m_tdata}, 19'h0);
    check_eq({tag, "_frame_count"}, frame_count, 7'd0);
    check_eq({tag, "_fill_level"}, fill_level, 7'd0);
    check_eq({tag, "_drop_count"}, drop_count, 8'd0);
    check_eq({tag, "_overflow"}, overflow_pulse, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    resn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    model_clear();
    #1;
    reset_outputs_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resn = 1'b1;
    idle(1);
  endtask

  task automatic set_side(input logic [3:0] d, input logic [1:0] id, input logic [3:0] u);
    s_tdest = d; s_tid = id; s_tuser = u;
  endtask

  initial begin
    resn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    m_tready = 1'b0; rand_rdy = 1'b0;
    set_side(4'h0, 2'h0, 4'h0);
    model_clear();

    // Single 3-byte frame with sideband, consumer always ready.
    do_reset("rst0");
    m_tready = 1'b1;
    set_side(4'd5, 2'd2, 4'hA);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check_eq("t1_no_valid_partial", m_tvalid, 1'b0);
    send(8'h33, 1'b1);
    check_eq("t1_valid_latency", m_tvalid, 1'b1);
    check_eq("t1_fc_one", frame_count, 7'd1);
    check_eq("t1_head", {m_tuser, m_tid, m_tdest, m_tdata}, {4'hA, 2'd2, 4'd5, 8'h11});
    idle(1);
    check_eq("t1_second", m_tdata, 8'h22);
    idle(1);
    check_eq("t1_last", {m_tlast, m_tdata}, {1'b1, 8'h33});
    idle(1);
    check_eq("t1_fc_zero", frame_count, 7'd0);

    // Partial frame is never presented.
    do_reset("rst1");
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    idle(10);
    check_eq("t2_valid", m_tvalid, 1'b0);
    check_eq("t2_fill", fill_level, 7'd0);

    // Fill to exactly DEPTH, then overflow with a 4-byte frame, then drain.
    do_reset("rst2");
    m_tready = 1'b0;
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < 8; b++) send(8'(f * 8 + b), (b == 7));
    check_eq("t3_fc8", frame_count, 7'd8);
    check_eq("t3_fill64", fill_level, 7'd64);
    send(8'hE0, 1'b0);
    check_eq("t3_pulse", overflow_pulse, 1'b1);
    check_eq("t3_drop1", drop_count, 8'd1);
    send(8'hE1, 1'b0);
    check_eq("t3_pulse_once", overflow_pulse, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b1);
    check_eq("t3_fill_kept", fill_level, 7'd64);
    m_tready = 1'b1;
    idle(70);
    check_eq("t3_drained", fill_level, 7'd0);

    // Oversize frame into an empty FIFO, then a normal frame.
    do_reset("rst3");
    m_tready = 1'b1;
    for (int b = 0; b < 70; b++) send(8'(b), (b == 69));
    check_eq("t4_drop1", drop_count, 8'd1);
    check_eq("t4_fc0", frame_count, 7'd0);
    set_side(4'd3, 2'd1, 4'h6);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    check_eq("t4_next_head", m_tdata, 8'hC1);
    idle(4);

    // Randomized traffic with a randomly stalling consumer.
    do_reset("rst4");
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len = $urandom_range(1, 16);
      int guard = 0;
      while ((q_c.size() + q_p.size()) > DEPTH - 16 && guard < 1000) begin
        idle(1);
        guard++;
      end
      check_eq("t5_wait_bound", (guard >= 1000), 1'b0);
      set_side(4'($urandom), 2'($urandom), 4'($urandom));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(8'($urandom), (b == len - 1));
      end
    end
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    idle(80);
    check_eq("t5_no_drops", drop_count, 8'd0);
    check_eq("t5_empty", fill_level, 7'd0);

    // Reset asserted mid-frame with two frames stored.
    m_tready = 1'b0;
    set_side(4'd7, 2'd3, 4'h1);
    for (int b = 0; b < 6; b++) send(8'h50 + 8'(b), (b % 3 == 2));
    send(8'h60, 1'b0);
    send(8'h61, 1'b0);
    check_eq("t6_fc2", frame_count, 7'd2);
    #2;
    do_reset("t6_async");
    m_tready = 1'b1;
    set_side(4'd9, 2'd0, 4'h3);
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b1);
    check_eq("t6_new_frame", {m_tvalid, m_tdata}, {1'b1, 8'hA5});
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
